cpu_run_ctrl: RTL

- Synthesizable, parametrised run controller for the pipelined CPU.
- Sequences the CPU's reset for a programmable number of cycles, runs the core, and detects program end by halt, which is a repeated branch-to-self retirement.
- Aborts the run on a cycle-count timeout.
- Keeps saturating performance counters for cycles, retired instructions and stall cycles.
- Sits beside the cpu instance, in the test harness or on the FPGA top.

---
 rtl/cpu_run_pkg.sv | 17 +
 rtl/sat_counter.sv | 36 +++
 rtl/cpu_run_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM states and completion codes.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        DC_NONE    = 2'b00,
        DC_HALT    = 2'b01,
        DC_TIMEOUT = 2'b10
    } done_code_t;

endpackage : cpu_run_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined CPU: sequences the core reset, runs it,
// ends the run on halt (repeated branch-to-self) or timeout, and keeps
// saturating cycle / retire / stall counters.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 1000,
    parameter int HALT_REPEAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              retire_valid,
    input  logic [ADDR_W-1:0] retire_pc,
    input  logic              stall,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic [1:0]        done_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retire_count,
    output logic [CNT_W-1:0]  stall_count
);

    // Reset-phase counter only needs to reach RST_CYCLES-1.
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    // Repeat counter must be able to represent HALT_REPEAT itself.
    localparam int REP_W = $clog2(HALT_REPEAT + 1);
    localparam logic [REP_W-1:0] HALT_AT = REP_W'(HALT_REPEAT);
    localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};

    // Cycle count value seen during the final permitted RUN cycle.
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    run_state_t        state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              have_last_q, have_last_d;
    done_code_t        done_code_q, done_code_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              in_run;
    logic [REP_W-1:0]  rep_next;
    logic              halt_hit;
    logic              timeout_hit;

    // Repeat count this retirement would produce; first retirement of a run starts at 1.
    always_comb begin
        rep_next = REP_W'(1);
        if (have_last_q && (retire_pc == last_pc_q)) begin
            rep_next = (rep_q == REP_MAX) ? rep_q : rep_q + REP_W'(1);
        end
    end

    assign halt_hit    = retire_valid && (rep_next == HALT_AT);
    assign timeout_hit = (cycle_count == LAST_CYCLE);

    // FSM next-state, halt tracker update and registered-output next values.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        last_pc_d   = last_pc_q;
        rep_d       = rep_q;
        have_last_d = have_last_q;
        done_code_d = done_code_q;
        cnt_clr     = 1'b0;
        in_run      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RST;
                    rst_cnt_d   = '0;
                    done_code_d = DC_NONE;
                    have_last_d = 1'b0;
                    rep_d       = '0;
                    cnt_clr     = 1'b1;
                end
            end
            RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            RUN: begin
                in_run = 1'b1;
                // Cycles without a retirement leave the tracker alone so stalls
                // inside a halt loop do not reset the repeat count.
                if (retire_valid) begin
                    last_pc_d   = retire_pc;
                    rep_d       = rep_next;
                    have_last_d = 1'b1;
                end
                // Halt takes priority when both end conditions hit together.
                if (halt_hit) begin
                    state_d     = DONE;
                    done_code_d = DC_HALT;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    done_code_d = DC_TIMEOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_reset_d = (state_d != RUN);
        running_d   = (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    // State, tracker and output registers; reset aborts any run without reporting done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            last_pc_q   <= '0;
            rep_q       <= '0;
            have_last_q <= 1'b0;
            done_code_q <= DC_NONE;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            last_pc_q   <= last_pc_d;
            rep_q       <= rep_d;
            have_last_q <= have_last_d;
            done_code_q <= done_code_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (in_run),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (in_run && retire_valid),
        .count (retire_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (in_run && stall),
        .count (stall_count)
    );

    assign cpu_reset = cpu_reset_q;
    assign running   = running_q;
    assign done      = done_q;
    assign done_code = done_code_q;

endmodule : cpu_run_ctrl
